pulse_scheduler: RTL and testbench
==================================

Name: pulse_scheduler

Overview:
- Queues up to DEPTH timed pulse jobs and fires each one against Thunderbolt GPS time on a single pulse output.
- A job is a start time, a pulse width, a period and a repeat count.
- Sits between the host-config register block and the board pulse output.
- Sequences arm, pulse and gap phases, and reports fired, missed and completed jobs to firmware.

Parameters:
- CLKS_PER_US, 10, i_clk cycles per microsecond.
- DEPTH, 4, job queue entries (power of 2).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  scheduler run enable
- i_flush  in  1  clear queue, abort the active job
- i_wr_en  in  1  push a job (accepted when o_wr_ready)
- i_wr_year  in  16  start year
- i_wr_month / i_wr_day / i_wr_hour / i_wr_minutes / i_wr_seconds  in  8 each  start time fields
- i_wr_width_us  in  32  pulse high time in us
- i_wr_period_us  in  32  low gap between pulses in us
- i_wr_repeat  in  8  extra pulses (total pulses = repeat+1)
- i_thunder_packet_dv  in  1  Thunderbolt time valid strobe
- i_thunder_year  in  16; i_thunder_month/day/hour/minutes/seconds  in  8 each
- o_wr_ready  out  1  queue not full
- o_overflow  out  1  1-cycle: write attempted while full
- o_count  out  $clog2(DEPTH)+1  queued jobs, including the active one
- o_pulse  out  1  registered pulse output
- o_busy  out  1  state is PULSE or GAP
- o_fired  out  1  1-cycle strobe at each pulse rising edge
- o_missed  out  1  1-cycle: head job was late, dropped
- o_done  out  1  1-cycle: job finished all pulses, popped

Behaviour:
- Reset (async): state IDLE; queue empty; counters 0. Outputs: o_pulse=0, o_busy=0, o_fired=0, o_missed=0, o_done=0, o_overflow=0, o_count=0, o_wr_ready=1.
- Time key: 56-bit concatenation {year, month, day, hour, minutes, seconds}. Comparisons are unsigned on the key.
- Clamping at push: width_us=0 stored as 1; period_us=0 stored as 1.
- Queue is FIFO. A push while full is ignored and raises o_overflow. Push and pop in the same cycle are both honoured; o_count is unchanged.
- i_flush: empties queue, state to IDLE, o_pulse=0 next cycle. Flush beats a same-cycle push; the push is dropped with no o_overflow.
- us tick: a prescaler counts 0..CLKS_PER_US-1. It restarts at 0 on every state entry.
- IDLE: moves to ARMED when i_enable=1 and o_count>0.
- ARMED: acts only on i_thunder_packet_dv=1.
  - thunder key == head key: go to PULSE; o_pulse=1 and o_fired=1 in the next cycle.
  - thunder key > head key: pop the head, o_missed=1, go to IDLE.
  - thunder key < head key: stay in ARMED.
- PULSE: o_pulse stays high exactly width_us*CLKS_PER_US cycles.
  - Pulses remaining > 0: go to GAP.
  - Otherwise: pop, o_done=1, go to IDLE.
- GAP: o_pulse stays low exactly period_us*CLKS_PER_US cycles, then returns to PULSE with o_fired=1. Pulse-to-pulse rising-edge spacing is (width+period)*CLKS_PER_US cycles.
- Repeat counter: loaded with i_wr_repeat on entry to PULSE from ARMED, decremented at each GAP exit.
- i_enable=0 in any state: go to IDLE next cycle, o_pulse=0. The head job is retained, not popped; re-enabling re-arms it, so a passed time yields o_missed.
- us counter is 32 bits and never wraps within a legal width or period.
- i_wr_* fields are captured only on an accepted push.
- Thunderbolt inputs are used only in the cycle where i_thunder_packet_dv=1.

Decomposition:
- Package pulse_sched_pkg holds:
  - state encodings IDLE=0, ARMED=1, PULSE=2, GAP=3
  - TIME_KEY_W=56
  - job record field widths
  - a function building the time key from its fields
- Sub-module sched_job_fifo: DEPTH-deep FIFO of packed jobs (56+32+32+8 bits). It provides push/pop/flush, full/empty and count; the head job is readable without a pop.

Test Plan:
- Single shot:
  - Stimulus: push 2024-06-01 12:00:05, width 3, repeat 0, enable=1; dv with matching time.
  - Response: o_pulse high exactly 30 cycles starting the cycle after dv; then o_done=1 and o_count 1->0.
- Repeat train:
  - Stimulus: width 2, period 5, repeat 2.
  - Response: three pulses, each 20 cycles high separated by 50 low; three o_fired strobes; one o_done.
- Late job:
  - Stimulus: head 12:00:05; dv 12:00:06.
  - Response: o_missed=1, o_pulse never rises, o_count decrements.
  - Stimulus: next dv at 12:00:04 with another job queued.
  - Response: stays in ARMED.
- Full queue:
  - Stimulus: 5 pushes with no dv.
  - Response: 5th gives o_overflow=1, o_count=4, o_wr_ready=0.
  - Stimulus: same-cycle push+pop at count 3.
  - Response: count stays 3.
- Abort:
  - Stimulus: assert i_flush mid-GAP.
  - Response: queue empty, o_busy=0 next cycle.
  - Stimulus: assert i_rst mid-PULSE.
  - Response: o_pulse=0 immediately (async), o_count=0.
- Disable:
  - Stimulus: i_enable=0 during PULSE, then 1.
  - Response: pulse drops next cycle, job retained; a later dv past its start time gives o_missed.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg
// Shared types for the pulse scheduler: FSM state encoding, time-key and
// job-record widths, the packed job record stored in the queue, and a
// helper that builds the 56-bit time key from broken-down GPS time fields.
package pulse_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int TIME_KEY_W = 56;
  localparam int YEAR_W     = 16;
  localparam int FIELD_W    = 8;
  localparam int US_W       = 32;
  localparam int REP_W      = 8;

  typedef struct packed {
    logic [TIME_KEY_W-1:0] key;
    logic [US_W-1:0]       width_us;
    logic [US_W-1:0]       period_us;
    logic [REP_W-1:0]      repeat_n;
  } job_t;

  localparam int JOB_W = $bits(job_t);

  // Key ordering matches calendar ordering because the most significant
  // field sits in the most significant bits.
  function automatic logic [TIME_KEY_W-1:0] make_time_key(
    input logic [YEAR_W-1:0]  year,
    input logic [FIELD_W-1:0] month,
    input logic [FIELD_W-1:0] day,
    input logic [FIELD_W-1:0] hour,
    input logic [FIELD_W-1:0] minutes,
    input logic [FIELD_W-1:0] seconds
  );
    return {year, month, day, hour, minutes, seconds};
  endfunction

endpackage

// File: rtl/sched_job_fifo.sv
// sched_job_fifo
// DEPTH-deep FIFO of packed job records. The head entry is always visible
// on head_job without popping, so the scheduler can work on the active job
// in place and pop it only when the job is finished or dropped.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, wr_job    enqueue wr_job; ignored when full or flushing
//   pop             dequeue head; ignored when empty or flushing
//   flush           empty the queue (wins over push/pop)
//   head_job        current head entry (undefined when empty)
//   full, empty     occupancy flags
//   count           number of stored entries
module sched_job_fifo
  import pulse_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  job_t                       wr_job,
  input  logic                       pop,
  input  logic                       flush,
  output job_t                       head_job,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  job_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full && !flush;
  assign pop_ok   = pop && !empty && !flush;
  assign head_job = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_job;
  end

endmodule

// File: rtl/pulse_scheduler.sv
// pulse_scheduler
// Queues timed pulse jobs and fires them on o_pulse when Thunderbolt GPS
// time matches the head job's start time. Each job produces repeat+1 high
// pulses of width_us separated by low gaps of period_us.
// Ports:
//   i_clk, i_rst              clock, asynchronous active-high reset
//   i_enable                  run enable; low returns to IDLE, job kept
//   i_flush                   empty queue, abort active job
//   i_wr_*                    job push interface (i_wr_en / o_wr_ready)
//   i_thunder_*               GPS time, sampled only when packet_dv=1
//   o_wr_ready, o_overflow    queue not full / push attempted while full
//   o_count                   queued jobs including the active one
//   o_pulse, o_busy           pulse output / state is PULSE or GAP
//   o_fired, o_missed, o_done 1-cycle event strobes
//   o_state                   FSM state, for debug observation
// Handshake: a push is accepted on any cycle where i_wr_en=1 and
// o_wr_ready=1 and i_flush=0; i_wr_* are captured only on that cycle.
// i_wr_en=1 with o_wr_ready=0 drops the push and pulses o_overflow.
module pulse_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int CLKS_PER_US = 10,
  parameter int DEPTH       = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic                   i_wr_en,
  input  logic [15:0]            i_wr_year,
  input  logic [7:0]             i_wr_month,
  input  logic [7:0]             i_wr_day,
  input  logic [7:0]             i_wr_hour,
  input  logic [7:0]             i_wr_minutes,
  input  logic [7:0]             i_wr_seconds,
  input  logic [31:0]            i_wr_width_us,
  input  logic [31:0]            i_wr_period_us,
  input  logic [7:0]             i_wr_repeat,
  input  logic                   i_thunder_packet_dv,
  input  logic [15:0]            i_thunder_year,
  input  logic [7:0]             i_thunder_month,
  input  logic [7:0]             i_thunder_day,
  input  logic [7:0]             i_thunder_hour,
  input  logic [7:0]             i_thunder_minutes,
  input  logic [7:0]             i_thunder_seconds,
  output logic                   o_wr_ready,
  output logic                   o_overflow,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_pulse,
  output logic                   o_busy,
  output logic                   o_fired,
  output logic                   o_missed,
  output logic                   o_done,
  output state_e                 o_state
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  state_e                state, state_n;
  logic [PW-1:0]         presc;
  logic [US_W-1:0]       us_cnt;
  logic [REP_W-1:0]      rep_cnt;

  job_t                  wr_job;
  job_t                  head_job;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  logic [TIME_KEY_W-1:0] thunder_key;
  logic                  us_tick;
  logic                  pulse_end;
  logic                  gap_end;
  logic                  fire_n, miss_n, done_n;
  logic                  load_rep, dec_rep;

  // Zero width or period would never terminate the phase counter, so the
  // shortest legal value is substituted at capture time.
  always_comb begin
    wr_job           = '0;
    wr_job.key       = make_time_key(i_wr_year, i_wr_month, i_wr_day,
                                     i_wr_hour, i_wr_minutes, i_wr_seconds);
    wr_job.width_us  = (i_wr_width_us  == '0) ? 32'd1 : i_wr_width_us;
    wr_job.period_us = (i_wr_period_us == '0) ? 32'd1 : i_wr_period_us;
    wr_job.repeat_n  = i_wr_repeat;
  end

  sched_job_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (i_wr_en),
    .wr_job   (wr_job),
    .pop      (fifo_pop),
    .flush    (i_flush),
    .head_job (head_job),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (o_count)
  );

  assign thunder_key = make_time_key(i_thunder_year, i_thunder_month,
                                     i_thunder_day, i_thunder_hour,
                                     i_thunder_minutes, i_thunder_seconds);

  // A phase lasting N us ends on the last clock of its Nth microsecond,
  // giving exactly N*CLKS_PER_US cycles in the state.
  assign us_tick   = (presc == PW'(CLKS_PER_US - 1));
  assign pulse_end = us_tick && (us_cnt == head_job.width_us - 32'd1);
  assign gap_end   = us_tick && (us_cnt == head_job.period_us - 32'd1);

  always_comb begin
    state_n  = state;
    fifo_pop = 1'b0;
    fire_n   = 1'b0;
    miss_n   = 1'b0;
    done_n   = 1'b0;
    load_rep = 1'b0;
    dec_rep  = 1'b0;
    if (i_flush || !i_enable) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state_n = ST_ARMED;
        end
        ST_ARMED: begin
          if (i_thunder_packet_dv) begin
            if (thunder_key == head_job.key) begin
              state_n  = ST_PULSE;
              fire_n   = 1'b1;
              load_rep = 1'b1;
            end else if (thunder_key > head_job.key) begin
              state_n  = ST_IDLE;
              fifo_pop = 1'b1;
              miss_n   = 1'b1;
            end
          end
        end
        ST_PULSE: begin
          if (pulse_end) begin
            if (rep_cnt != '0) begin
              state_n = ST_GAP;
            end else begin
              state_n  = ST_IDLE;
              fifo_pop = 1'b1;
              done_n   = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_end) begin
            state_n = ST_PULSE;
            fire_n  = 1'b1;
            dec_rep = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Prescaler and us counter restart on every state change so each phase
  // is timed from its own first cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (state_n != state) begin
      presc  <= '0;
      us_cnt <= '0;
    end else if (us_tick) begin
      presc  <= '0;
      us_cnt <= us_cnt + 32'd1;
    end else begin
      presc  <= presc + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rep_cnt <= '0;
    end else if (load_rep) begin
      rep_cnt <= head_job.repeat_n;
    end else if (dec_rep) begin
      rep_cnt <= rep_cnt - 1'b1;
    end
  end

  // Registered outputs: o_pulse tracks the state register one-for-one,
  // and the strobes line up with the cycle the state change takes effect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_pulse    <= 1'b0;
      o_fired    <= 1'b0;
      o_missed   <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_pulse    <= (state_n == ST_PULSE);
      o_fired    <= fire_n;
      o_missed   <= miss_n;
      o_done     <= done_n;
      o_overflow <= i_wr_en && fifo_full && !i_flush;
    end
  end

  assign o_wr_ready = !fifo_full;
  assign o_busy     = (state == ST_PULSE) || (state == ST_GAP);
  assign o_state    = state;

endmodule

// File: tb/tb_pulse_scheduler.sv
// tb_pulse_scheduler
// Directed bench for pulse_scheduler: queue-occupancy vector table plus
// hand-written timing sequences. A pulse-length monitor compares each
// completed high pulse against an expected queue.
module tb_pulse_scheduler;
  import pulse_sched_pkg::*;

  localparam int CPU   = 10;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        enable = 1'b0, flush = 1'b0, wr_en = 1'b0, dv = 1'b0;
  logic [15:0] wr_year = 16'd2024, th_year = 16'd2024;
  logic [7:0]  wr_month = 8'd6, wr_day = 8'd1, wr_hour = 8'd12;
  logic [7:0]  wr_min = 8'd0, wr_sec = 8'd0;
  logic [7:0]  th_month = 8'd6, th_day = 8'd1, th_hour = 8'd12;
  logic [7:0]  th_min = 8'd0, th_sec = 8'd0;
  logic [31:0] wr_width = 32'd1, wr_period = 32'd1;
  logic [7:0]  wr_rep = 8'd0;

  logic        o_wr_ready, o_overflow, o_pulse, o_busy;
  logic        o_fired, o_missed, o_done;
  logic [2:0]  o_count;
  logic [1:0]  o_state;

  pulse_scheduler #(.CLKS_PER_US(CPU), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_enable            (enable),
    .i_flush             (flush),
    .i_wr_en             (wr_en),
    .i_wr_year           (wr_year),
    .i_wr_month          (wr_month),
    .i_wr_day            (wr_day),
    .i_wr_hour           (wr_hour),
    .i_wr_minutes        (wr_min),
    .i_wr_seconds        (wr_sec),
    .i_wr_width_us       (wr_width),
    .i_wr_period_us      (wr_period),
    .i_wr_repeat         (wr_rep),
    .i_thunder_packet_dv (dv),
    .i_thunder_year      (th_year),
    .i_thunder_month     (th_month),
    .i_thunder_day       (th_day),
    .i_thunder_hour      (th_hour),
    .i_thunder_minutes   (th_min),
    .i_thunder_seconds   (th_sec),
    .o_wr_ready          (o_wr_ready),
    .o_overflow          (o_overflow),
    .o_count             (o_count),
    .o_pulse             (o_pulse),
    .o_busy              (o_busy),
    .o_fired             (o_fired),
    .o_missed            (o_missed),
    .o_done              (o_done),
    .o_state             (o_state)
  );

  // ---------------- scoreboard ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          fire_times[$];
  int          hi_len = 0, cyc_n = 0, fired_cnt = 0, done_cnt = 0;
  logic [31:0] exp_w;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      hi_len = 0;
    end else if (o_pulse) begin
      hi_len++;
    end else if (hi_len != 0) begin
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        check("pulse_len", hi_len, exp_w);
      end
      hi_len = 0;
    end
    if (o_fired) begin
      fired_cnt++;
      fire_times.push_back(cyc_n);
    end
    if (o_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input logic [7:0] mi, input logic [7:0] se,
                        input logic [31:0] w, input logic [31:0] p,
                        input logic [7:0] r);
    wr_min = mi; wr_sec = se; wr_width = w; wr_period = p; wr_rep = r;
  endtask

  task automatic push_job(input logic [7:0] mi, input logic [7:0] se,
                          input logic [31:0] w, input logic [31:0] p,
                          input logic [7:0] r);
    set_wr(mi, se, w, p, r);
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic set_th(input logic [7:0] mi, input logic [7:0] se);
    th_min = mi; th_sec = se;
  endtask

  task automatic send_dv(input logic [7:0] mi, input logic [7:0] se);
    set_th(mi, se);
    dv = 1'b1;
    cyc();
    dv = 1'b0;
  endtask

  task automatic reset_cnts();
    fired_cnt = 0;
    done_cnt  = 0;
    fire_times.delete();
  endtask

  // n = cycles until o_done is seen, -1 if it never comes within max
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      cyc();
      if (o_done) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic wr;
    logic fl;
    int   exp_count;
    logic exp_ready;
    logic exp_ovf;
  } vec_t;
  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- test ----------------
  initial begin
    int n;
    tbl[0] = '{1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 2, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 4, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 4, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 0, 1'b1, 1'b0};

    // reset values
    repeat (3) cyc();
    check("rst_pulse", o_pulse, 0);
    check("rst_busy", o_busy, 0);
    check("rst_fired", o_fired, 0);
    check("rst_missed", o_missed, 0);
    check("rst_done", o_done, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_count", o_count, 0);
    check("rst_wr_ready", o_wr_ready, 1);
    rst = 1'b0;
    cyc();

    // single shot: 3 us at 12:00:05
    enable = 1'b1;
    reset_cnts();
    push_job(8'd0, 8'd5, 32'd3, 32'd0, 8'd0);
    check("t1_count", o_count, 1);
    cyc();
    check("t1_armed", o_state, 1);
    exp_q.push_back(32'd30);
    send_dv(8'd0, 8'd5);
    check("t1_pulse_rise", o_pulse, 1);
    check("t1_fired", o_fired, 1);
    check("t1_busy", o_busy, 1);
    wait_done(60, n);
    check("t1_done_lat", n, 30);
    check("t1_count_after", o_count, 0);
    check("t1_pulse_after", o_pulse, 0);
    cyc();
    check("t1_fired_cnt", fired_cnt, 1);

    // repeat train: width 2, period 5, repeat 2
    reset_cnts();
    push_job(8'd0, 8'd10, 32'd2, 32'd5, 8'd2);
    cyc();
    repeat (3) exp_q.push_back(32'd20);
    send_dv(8'd0, 8'd10);
    wait_done(200, n);
    check("t2_done_lat", n, 160);
    cyc();
    check("t2_fired_cnt", fired_cnt, 3);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_fire_n", fire_times.size(), 3);
    if (fire_times.size() >= 3) begin
      check("t2_spacing0", fire_times[1] - fire_times[0], 70);
      check("t2_spacing1", fire_times[2] - fire_times[1], 70);
    end

    // zero width/period clamp to 1 us
    reset_cnts();
    push_job(8'd0, 8'd20, 32'd0, 32'd0, 8'd1);
    cyc();
    repeat (2) exp_q.push_back(32'd10);
    send_dv(8'd0, 8'd20);
    wait_done(100, n);
    check("t7_done_lat", n, 30);
    cyc();
    check("t7_fire_n", fire_times.size(), 2);
    if (fire_times.size() >= 2)
      check("t7_spacing", fire_times[1] - fire_times[0], 20);

    // late job then early time
    push_job(8'd0, 8'd5, 32'd1, 32'd1, 8'd0);
    push_job(8'd0, 8'd40, 32'd1, 32'd1, 8'd0);
    check("t3_count2", o_count, 2);
    send_dv(8'd0, 8'd6);
    check("t3_missed", o_missed, 1);
    check("t3_count1", o_count, 1);
    check("t3_no_pulse", o_pulse, 0);
    check("t3_idle", o_state, 0);
    cyc();
    check("t3_rearmed", o_state, 1);
    send_dv(8'd0, 8'd4);
    check("t3_early_armed", o_state, 1);
    check("t3_early_missed", o_missed, 0);
    check("t3_early_busy", o_busy, 0);
    check("t3_early_count", o_count, 1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t3_flush_count", o_count, 0);
    check("t3_flush_state", o_state, 0);

    // full queue vector table (scheduler disabled)
    enable = 1'b0;
    set_wr(8'd1, 8'd0, 32'd1, 32'd1, 8'd0);
    cyc();
    for (int i = 0; i < 9; i++) begin
      wr_en = tbl[i].wr;
      flush = tbl[i].fl;
      cyc();
      wr_en = 1'b0;
      flush = 1'b0;
      check($sformatf("vec%0d_count", i), o_count, tbl[i].exp_count);
      check($sformatf("vec%0d_ready", i), o_wr_ready, tbl[i].exp_ready);
      check($sformatf("vec%0d_ovf", i), o_overflow, tbl[i].exp_ovf);
    end

    // same-cycle push and pop at count 3
    push_job(8'd0, 8'd5, 32'd1, 32'd1, 8'd0);
    push_job(8'd0, 8'd50, 32'd1, 32'd1, 8'd0);
    push_job(8'd0, 8'd51, 32'd1, 32'd1, 8'd0);
    check("t4_count3", o_count, 3);
    enable = 1'b1;
    cyc();
    set_wr(8'd0, 8'd52, 32'd1, 32'd1, 8'd0);
    set_th(8'd0, 8'd6);
    wr_en = 1'b1;
    dv = 1'b1;
    cyc();
    wr_en = 1'b0;
    dv = 1'b0;
    check("t4_pushpop_count", o_count, 3);
    check("t4_pushpop_missed", o_missed, 1);
    check("t4_pushpop_ovf", o_overflow, 0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // flush mid-GAP
    push_job(8'd1, 8'd0, 32'd0, 32'd5, 8'd1);
    cyc();
    exp_q.push_back(32'd10);
    send_dv(8'd1, 8'd0);
    repeat (15) cyc();
    check("t5_gap_state", o_state, 3);
    check("t5_gap_busy", o_busy, 1);
    check("t5_gap_pulse", o_pulse, 0);
    push_job(8'd1, 8'd30, 32'd1, 32'd1, 8'd0);
    check("t5_count2", o_count, 2);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t5_flush_busy", o_busy, 0);
    check("t5_flush_count", o_count, 0);
    check("t5_flush_state", o_state, 0);

    // async reset mid-PULSE
    push_job(8'd2, 8'd0, 32'd4, 32'd1, 8'd0);
    cyc();
    send_dv(8'd2, 8'd0);
    repeat (5) cyc();
    check("t5b_pulse_high", o_pulse, 1);
    rst = 1'b1;
    #1;
    check("t5b_rst_pulse", o_pulse, 0);
    check("t5b_rst_count", o_count, 0);
    check("t5b_rst_busy", o_busy, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // disable during PULSE, re-enable after start time
    push_job(8'd3, 8'd0, 32'd4, 32'd1, 8'd0);
    cyc();
    send_dv(8'd3, 8'd0);
    repeat (5) cyc();
    check("t6_pulse_high", o_pulse, 1);
    enable = 1'b0;
    cyc();
    check("t6_dis_pulse", o_pulse, 0);
    check("t6_dis_busy", o_busy, 0);
    check("t6_dis_count", o_count, 1);
    enable = 1'b1;
    cyc();
    check("t6_rearmed", o_state, 1);
    send_dv(8'd3, 8'd1);
    check("t6_missed", o_missed, 1);
    check("t6_count", o_count, 0);
    check("t6_pulse", o_pulse, 0);

    repeat (5) cyc();
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
